// File: rtl/countdown_timer_param.sv
// countdown_timer_param: BCD countdown timer with a built-in prescaler, runtime
// load/start/pause/resume, a one-cycle done pulse, a timed beeper and direct
// seven-segment drive for every digit.
module countdown_timer_param #(
    parameter int unsigned CLK_DIV        = 50_000_000,
    parameter int unsigned DIGITS         = 2,
    parameter int unsigned BEEP_TICKS     = 3,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  start,
    input  logic                  pause,
    output logic [4*DIGITS-1:0]   time_bcd,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  beep,
    output logic                  running,
    output logic                  done
);

    localparam int unsigned PW = $clog2(CLK_DIV);
    localparam int unsigned BW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_TICKS - 1);
    localparam logic [6:0]    SEG_MASK  = {7{SEG_ACTIVE_LOW}};

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPaused,
        StExpired
    } state_e;

    state_e                state_q, state_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [4*DIGITS-1:0]   time_q, time_d;
    logic [BW-1:0]         beep_cnt_q, beep_cnt_d;
    logic                  beep_q, beep_d;
    logic                  done_q, done_d;

    logic                  tick;
    logic                  advance;
    logic [PW-1:0]         presc_step;
    logic [4*DIGITS-1:0]   time_dec;

    // Saturate every nibble of an incoming value to a legal BCD digit.
    function automatic logic [4*DIGITS-1:0] bcd_clamp(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    // Subtract one in BCD; a zero digit borrows from the next one up.
    function automatic logic [4*DIGITS-1:0] bcd_dec(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        logic                borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Segment pattern {g,f,e,d,c,b,a} for one active-high digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] p;
        unique case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    assign tick       = (presc_q == PRESC_MAX);
    assign presc_step = tick ? '0 : presc_q + PW'(1);
    assign time_dec   = bcd_dec(time_q);

    // Next-state logic: load overrides everything, then per-state handling.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        time_d     = time_q;
        beep_cnt_d = beep_cnt_q;
        beep_d     = beep_q;
        done_d     = 1'b0;
        advance    = 1'b0;

        if (load) begin
            time_d  = bcd_clamp(load_value);
            presc_d = '0;
            beep_d  = 1'b0;
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && (time_q != '0)) begin
                        state_d = StRun;
                        presc_d = '0;
                    end
                end
                StRun: begin
                    if (pause) begin
                        state_d = StPaused;
                    end else begin
                        advance = 1'b1;
                    end
                end
                StPaused: begin
                    // The resume edge counts as a run cycle so a pause costs
                    // exactly the number of cycles it lasted.
                    if (start && !pause) begin
                        state_d = StRun;
                        advance = 1'b1;
                    end
                end
                StExpired: begin
                    presc_d = presc_step;
                    if (tick) begin
                        if (beep_cnt_q == BEEP_LAST) begin
                            beep_d  = 1'b0;
                            time_d  = '0;
                            state_d = StIdle;
                        end else begin
                            beep_cnt_d = beep_cnt_q + BW'(1);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase

            if (advance) begin
                presc_d = presc_step;
                if (tick) begin
                    time_d = time_dec;
                    if (time_dec == '0) begin
                        state_d    = StExpired;
                        done_d     = 1'b1;
                        beep_d     = 1'b1;
                        beep_cnt_d = '0;
                    end
                end
            end
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            presc_q    <= '0;
            time_q     <= '0;
            beep_cnt_q <= '0;
            beep_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            time_q     <= time_d;
            beep_cnt_q <= beep_cnt_d;
            beep_q     <= beep_d;
            done_q     <= done_d;
        end
    end

    // Seven-segment decode of the registered count, no added latency.
    always_comb begin
        seg = '0;
        for (int i = 0; i < DIGITS; i++) begin
            seg[7*i +: 7] = seg_decode(time_q[4*i +: 4]) ^ SEG_MASK;
        end
    end

    assign time_bcd = time_q;
    assign beep     = beep_q;
    assign done     = done_q;
    assign running  = (state_q == StRun);

endmodule
